// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding constants, request codes and the request bundle
// used by the instruction encoder and its format sub-block.
package instr_encoder_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [2:0] KIND_OP     = 3'd0;
  localparam logic [2:0] KIND_OP_IMM = 3'd1;
  localparam logic [2:0] KIND_LOAD   = 3'd2;
  localparam logic [2:0] KIND_STORE  = 3'd3;
  localparam logic [2:0] KIND_BRANCH = 3'd4;
  localparam logic [2:0] KIND_JAL    = 3'd5;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_SLT  = 3'd2;
  localparam logic [2:0] ALU_SLTU = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_OR   = 3'd5;
  localparam logic [2:0] ALU_XOR  = 3'd6;

  typedef struct packed {
    logic [2:0]  kind;
    logic [2:0]  alu_op;
    logic        cmp;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [20:0] imm;
  } enc_req_t;

  function automatic logic [2:0] alu_funct3(input logic [2:0] op);
    logic [2:0] f;
    f = F3_ADD;
    unique case (op)
      ALU_SLT:  f = F3_SLT;
      ALU_SLTU: f = F3_SLTU;
      ALU_AND:  f = F3_AND;
      ALU_OR:   f = F3_OR;
      ALU_XOR:  f = F3_XOR;
      default:  f = F3_ADD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_format.sv
// Combinational field-to-word packer for RV32I, flags
// requests that cannot be encoded.
module instr_format
  import instr_encoder_pkg::*;
(
  input  enc_req_t    req,
  output logic [31:0] word,
  output logic        illegal
);

  logic signed [20:0] imm;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       alu_ok;
  logic       i_ok;
  logic       b_ok;
  logic       j_ok;

  assign imm    = req.imm;
  assign f3     = alu_funct3(req.alu_op);
  assign f7     = (req.alu_op == ALU_SUB) ? F7_SUB : F7_ZERO;
  assign alu_ok = (req.alu_op != 3'd7);
  assign i_ok   = (imm >= -21'sd2048) && (imm <= 21'sd2047);
  assign b_ok   = (imm >= -21'sd4096) && (imm <= 21'sd4094)
                  && !imm[0];
  assign j_ok   = !imm[0];

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    unique case (1'b1)
      (req.kind == KIND_OP): begin
        word    = {f7, req.rs2, req.rs1, f3, req.rd, OPC_OP};
        illegal = !alu_ok;
      end
      (req.kind == KIND_OP_IMM): begin
        word    = {imm[11:0], req.rs1, f3, req.rd, OPC_OP_IMM};
        illegal = !alu_ok || (req.alu_op == ALU_SUB) || !i_ok;
      end
      (req.kind == KIND_LOAD): begin
        word    = {imm[11:0], req.rs1, F3_W, req.rd, OPC_LOAD};
        illegal = !i_ok;
      end
      (req.kind == KIND_STORE): begin
        word    = {imm[11:5], req.rs2, req.rs1, F3_W,
                   imm[4:0], OPC_STORE};
        illegal = !i_ok;
      end
      (req.kind == KIND_BRANCH): begin
        word    = {imm[12], imm[10:5], req.rs2, req.rs1,
                   req.cmp ? F3_BNE : F3_BEQ,
                   imm[4:1], imm[11], OPC_BRANCH};
        illegal = !b_ok;
      end
      (req.kind == KIND_JAL): begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12],
                   req.rd, OPC_JAL};
        illegal = !j_ok;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program builder: encodes field-level requests and streams the words
// into consecutive instruction-memory addresses.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic [2:0]        req_alu_op,
  input  logic              req_cmp,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [20:0]       req_imm,
  input  logic              req_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t state_q, state_d;
  enc_req_t req;
  logic [31:0] enc_word;
  logic enc_illegal;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] cnt_next;
  logic accept;
  logic wr;
  logic start_ok;

  assign req = '{kind: req_kind, alu_op: req_alu_op, cmp: req_cmp,
                 rd: req_rd, rs1: req_rs1, rs2: req_rs2,
                 imm: req_imm};

  instr_format u_fmt (
    .req     (req),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign req_ready = (state_q == S_RUN) && (!mem_we || mem_ready);
  assign accept    = req_valid && req_ready;
  assign wr        = accept && !enc_illegal;
  assign cnt_next  = count + CNT_W'(1);
  assign start_ok  = start
                     && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (accept && (req_last || (wr && cnt_next == CNT_MAX)))
          state_d = S_DRAIN;
      end
      // an illegal final request leaves nothing pending
      S_DRAIN: if (!mem_we || mem_ready) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= BASE;
      count     <= '0;
      err       <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE;
      mem_wdata <= '0;
    end else begin
      if (start_ok) begin
        addr  <= BASE;
        count <= '0;
        err   <= 1'b0;
      end
      if (wr) begin
        mem_we    <= 1'b1;
        mem_addr  <= addr;
        mem_wdata <= enc_word;
        addr      <= addr + ADDR_W'(4);
        count     <= cnt_next;
      end else if (mem_ready) begin
        mem_we <= 1'b0;
      end
      if (accept && enc_illegal) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: vector table, directed handshake sequences
// and random programs against an arithmetic reference encoder.
module tb_instr_encoder;

  localparam int ADDR_W = 12;
  localparam int MAXW   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic req_valid = 1'b0;
  logic [2:0] req_kind = '0;
  logic [2:0] req_alu_op = '0;
  logic req_cmp = 1'b0;
  logic [4:0] req_rd = '0;
  logic [4:0] req_rs1 = '0;
  logic [4:0] req_rs2 = '0;
  logic [20:0] req_imm = '0;
  logic req_last = 1'b0;
  logic mem_ready = 1'b0;
  logic req_ready;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic busy;
  logic done;
  logic err;

  instr_encoder #(
    .ADDR_W(ADDR_W), .BASE_ADDR(0), .MAX_WORDS(MAXW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_alu_op(req_alu_op),
    .req_cmp(req_cmp), .req_rd(req_rd), .req_rs1(req_rs1),
    .req_rs2(req_rs2), .req_imm(req_imm), .req_last(req_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind; int alu; int cmp;
    int rd; int rs1; int rs2;
    int imm; int last;
  } req_t;

  typedef struct {
    req_t r;
    logic [31:0] word;
    bit bad;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  int n_total = 0;
  int n_pass = 0;
  bit rand_ready = 1'b0;
  wr_t wr_q[$];
  wr_t exp_q[$];
  vec_t vt[$];

  always @(negedge clk)
    if (rst_n && mem_we && mem_ready)
      wr_q.push_back('{32'(mem_addr), mem_wdata});

  always @(posedge clk) begin
    #1;
    if (rand_ready) mem_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h",
                  nm, act, exp);
  endtask

  function automatic req_t mk(int k, int a, int c, int rd, int s1,
                              int s2, int imm, int last);
    req_t r;
    r.kind = k; r.alu = a; r.cmp = c;
    r.rd = rd; r.rs1 = s1; r.rs2 = s2;
    r.imm = imm; r.last = last;
    return r;
  endfunction

  // Reference encoder built from the RV32I field layouts.
  function automatic logic [31:0] ref_enc(input req_t r,
                                          output bit bad);
    logic [31:0] u, w, rd, s1, s2, f;
    int imm;
    imm = r.imm;
    u = imm;
    rd = r.rd; s1 = r.rs1; s2 = r.rs2;
    case (r.alu)
      2: f = 2; 3: f = 3; 4: f = 7; 5: f = 6; 6: f = 4;
      default: f = 0;
    endcase
    bad = 1'b0;
    w = 0;
    case (r.kind)
      0: begin
        bad = r.alu > 6;
        w = ((r.alu == 1) ? 32'h20 : 32'h0) << 25 | s2 << 20
            | s1 << 15 | f << 12 | rd << 7 | 32'h33;
      end
      1: begin
        bad = r.alu > 6 || r.alu == 1 || imm < -2048 || imm > 2047;
        w = (u & 32'hFFF) << 20 | s1 << 15 | f << 12 | rd << 7
            | 32'h13;
      end
      2: begin
        bad = imm < -2048 || imm > 2047;
        w = (u & 32'hFFF) << 20 | s1 << 15 | 32'd2 << 12 | rd << 7
            | 32'h03;
      end
      3: begin
        bad = imm < -2048 || imm > 2047;
        w = ((u >> 5) & 32'h7F) << 25 | s2 << 20 | s1 << 15
            | 32'd2 << 12 | (u & 32'h1F) << 7 | 32'h23;
      end
      4: begin
        bad = imm < -4096 || imm > 4094 || (imm & 1) != 0;
        w = ((u >> 12) & 1) << 31 | ((u >> 5) & 32'h3F) << 25
            | s2 << 20 | s1 << 15 | 32'(r.cmp) << 12
            | ((u >> 1) & 32'hF) << 8 | ((u >> 11) & 1) << 7
            | 32'h63;
      end
      5: begin
        bad = (imm & 1) != 0;
        w = ((u >> 20) & 1) << 31 | ((u >> 1) & 32'h3FF) << 21
            | ((u >> 11) & 1) << 20 | ((u >> 12) & 32'hFF) << 12
            | rd << 7 | 32'h6F;
      end
      default: bad = 1'b1;
    endcase
    return w;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int m;
    r.kind = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7)
                                         : $urandom_range(0, 5);
    r.alu = $urandom_range(0, 7);
    r.cmp = $urandom_range(0, 1);
    r.rd = $urandom_range(0, 31);
    r.rs1 = $urandom_range(0, 31);
    r.rs2 = $urandom_range(0, 31);
    m = $urandom_range(0, 2);
    if (m == 0) r.imm = $urandom_range(0, 4200) - 2100;
    else if (m == 1) r.imm = $urandom_range(0, 8400) - 4200;
    else r.imm = $urandom_range(0, 2097151) - 1048576;
    r.last = ($urandom_range(0, 5) == 0);
    return r;
  endfunction

  task automatic set_req(input req_t r);
    req_kind = 3'(r.kind);
    req_alu_op = 3'(r.alu);
    req_cmp = r.cmp[0];
    req_rd = 5'(r.rd);
    req_rs1 = 5'(r.rs1);
    req_rs2 = 5'(r.rs2);
    req_imm = 21'(r.imm);
    req_last = r.last[0];
  endtask

  task automatic send(input req_t r);
    bit ok;
    ok = 1'b0;
    set_req(r);
    req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    chk("accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    chk("done", 32'(ok), 32'd1);
  endtask

  task automatic check_prog(input string nm);
    chk({nm, "_nwr"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      chk({nm, "_addr"}, wr_q[i].a, exp_q[i].a);
      chk({nm, "_data"}, wr_q[i].d, exp_q[i].d);
    end
    wr_q.delete();
    exp_q.delete();
  endtask

  initial begin
    req_t r;
    logic [31:0] w;
    bit bad;
    bit fin;
    bit exp_err;
    int n;

    vt.push_back('{mk(1,0,0,1,0,0,5,1),        32'h00500093, 0});
    vt.push_back('{mk(2,0,0,5,2,0,-4,1),       32'hFFC12283, 0});
    vt.push_back('{mk(1,0,0,1,0,0,-2048,1),    32'h80000093, 0});
    vt.push_back('{mk(0,6,0,4,5,6,0,1),        32'h0062C233, 0});
    vt.push_back('{mk(4,0,1,0,0,0,-4096,1),    32'h80001063, 0});
    vt.push_back('{mk(5,0,0,0,0,0,-2,1),       32'hFFFFF06F, 0});
    vt.push_back('{mk(1,1,0,1,0,0,5,1),        32'h0, 1});
    vt.push_back('{mk(0,7,0,1,2,3,0,1),        32'h0, 1});
    vt.push_back('{mk(1,0,0,1,0,0,2048,1),     32'h0, 1});
    vt.push_back('{mk(4,0,0,1,2,0,4096,1),     32'h0, 1});
    vt.push_back('{mk(5,0,0,1,0,0,17,1),       32'h0, 1});
    vt.push_back('{mk(6,0,0,1,0,0,0,1),        32'h0, 1});
    vt.push_back('{mk(7,0,0,1,0,0,0,1),        32'h0, 1});

    #12;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", mem_wdata, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    mem_ready = 1'b1;

    foreach (vt[i]) begin
      do_start();
      send(vt[i].r);
      req_valid = 1'b0;
      wait_done();
      if (!vt[i].bad) exp_q.push_back('{32'h0, vt[i].word});
      check_prog($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].bad));
    end

    // back-to-back OP ADD / OP SUB
    do_start();
    send(mk(0,0,0,3,1,2,0,0));
    chk("b2b_we0", 32'(mem_we), 1);
    chk("b2b_w0", mem_wdata, 32'h002081B3);
    send(mk(0,1,0,3,1,2,0,1));
    req_valid = 1'b0;
    chk("b2b_we1", 32'(mem_we), 1);
    chk("b2b_w1", mem_wdata, 32'h402081B3);
    chk("b2b_a1", 32'(mem_addr), 4);
    wait_done();
    exp_q.push_back('{0, 32'h002081B3});
    exp_q.push_back('{4, 32'h402081B3});
    check_prog("b2b");

    // backpressure on the second word
    do_start();
    send(mk(3,0,0,0,1,2,8,0));
    send(mk(4,0,0,0,1,2,8,0));
    mem_ready = 1'b0;
    set_req(mk(5,0,0,1,0,0,16,1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_we", 32'(mem_we), 1);
      chk("bp_addr", 32'(mem_addr), 4);
      chk("bp_data", mem_wdata, 32'h00208463);
      chk("bp_ready", 32'(req_ready), 0);
    end
    @(posedge clk); #1 mem_ready = 1'b1;
    send(mk(5,0,0,1,0,0,16,1));
    req_valid = 1'b0;
    wait_done();
    exp_q.push_back('{0, 32'h0020A423});
    exp_q.push_back('{4, 32'h00208463});
    exp_q.push_back('{8, 32'h010000EF});
    check_prog("bp");

    // illegal requests leave address untouched
    do_start();
    send(mk(1,0,0,1,0,0,2048,0));
    chk("ill_we0", 32'(mem_we), 0);
    chk("ill_err0", 32'(err), 1);
    send(mk(4,0,0,0,1,2,3,0));
    chk("ill_we1", 32'(mem_we), 0);
    send(mk(1,0,0,1,0,0,5,1));
    req_valid = 1'b0;
    wait_done();
    exp_q.push_back('{0, 32'h00500093});
    check_prog("ill");
    chk("ill_err", 32'(err), 1);

    // capacity limit with an endless stream
    do_start();
    set_req(mk(0,0,0,3,1,2,0,0));
    req_valid = 1'b1;
    repeat (20) @(negedge clk);
    chk("cap_ready", 32'(req_ready), 0);
    chk("cap_done", 32'(done), 1);
    for (int i = 0; i < MAXW; i++)
      exp_q.push_back('{32'(4 * i), 32'h002081B3});
    check_prog("cap");
    req_valid = 1'b0;
    do_start();
    send(mk(0,0,0,3,1,2,0,1));
    req_valid = 1'b0;
    wait_done();
    exp_q.push_back('{0, 32'h002081B3});
    check_prog("cap_restart");

    // random programs with random memory backpressure
    for (int p = 0; p < 30; p++) begin
      rand_ready = 1'b1;
      do_start();
      n = 0;
      fin = 1'b0;
      exp_err = 1'b0;
      while (!fin) begin
        r = rand_req();
        send(r);
        w = ref_enc(r, bad);
        if (bad) exp_err = 1'b1;
        else begin
          exp_q.push_back('{32'(4 * n), w});
          n++;
        end
        if (r.last != 0 || n == MAXW) fin = 1'b1;
      end
      req_valid = 1'b0;
      wait_done();
      rand_ready = 1'b0;
      mem_ready = 1'b1;
      check_prog($sformatf("rnd%0d", p));
      chk("rnd_err", 32'(err), 32'(exp_err));
      chk("rnd_ready", 32'(req_ready), 0);
    end

    // asynchronous reset with a word pending
    mem_ready = 1'b0;
    do_start();
    send(mk(0,0,0,3,1,2,0,0));
    chk("ar_pending", 32'(mem_we), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_we", 32'(mem_we), 0);
    chk("ar_ready", 32'(req_ready), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_done", 32'(done), 0);
    chk("ar_err", 32'(err), 0);
    chk("ar_addr", 32'(mem_addr), 0);
    chk("ar_wdata", mem_wdata, 0);
    req_valid = 1'b0;
    wr_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("ar_nowrite", 32'(wr_q.size()), 0);
    chk("ar_we_after", 32'(mem_we), 0);
    chk("ar_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
